// File: rtl/nes_clk_pkg.sv
// ---------------------------------------------------------------------------
// nes_clk_pkg
// Shared definitions for the NES core clock/reset infrastructure.
//   - seq_state_e : states of the PLL reset sequencer
//   - DEF_*       : default cycle counts for the sequencer parameters
//   - cnt_width   : width of a counter that must hold the largest of three
//                   cycle counts
//   - retry_width : width of the retry counter (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package nes_clk_pkg;

    // Sequencer states, from PLL reset through to normal operation or give-up.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_e;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;

    // Bits needed to count up to the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    // A zero-retry configuration would give a zero-width counter, so keep
    // at least one bit.
    function automatic int retry_width(input int max_retries);
        return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for WIDTH independent single-bit signals crossing
// into the clk domain. Each bit is synchronized on its own; no coherence
// between bits is implied.
//   clk      : destination clock
//   rst      : asynchronous, active-high reset; output resets to 0
//   async_in : signals from a foreign or asynchronous domain
//   sync_out : synchronized copy, two clk edges of latency
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // The first stage may go metastable; the second stage gives it a full
    // clock period to resolve before anything downstream looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Brings up the system PLL from the reference clock domain: pulses the PLL
// reset, waits for lock with a timeout and bounded retries, qualifies the
// lock as stable, and only then releases the system reset. Loss of lock or a
// software request restarts the sequence.
//   refclk         : reference clock, sole clock of the block
//   rst            : asynchronous, active-high reset
//   pll_locked     : PLL lock indication, asynchronous to refclk
//   soft_reset_req : one-cycle restart request, synchronous to refclk
//   pll_rst        : reset to the PLL
//   sys_rst        : active-high reset for the rest of the core
//   ready          : high only while running normally
//   lock_fail      : high only after all retries are exhausted
//   lock_lost      : sticky, lock dropped while running
//   retry_count    : attempts since the last good lock or soft reset
// ---------------------------------------------------------------------------
module pll_reset_sequencer
    import nes_clk_pkg::*;
#(
    parameter int  RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int  LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int  LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int  MAX_RETRIES         = DEF_MAX_RETRIES,
    localparam int RETRY_W             = retry_width(MAX_RETRIES)
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               soft_reset_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES);

    // The counter is cleared on state entry, so the N-th edge spent in a
    // state is the one that sees the count at N-1.
    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic lock_s;

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_q, lost_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    bit_sync #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk      (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    // Next-state logic. Each counting state advances the shared counter until
    // its terminal count; a software request overrides everything and also
    // wins over a simultaneous lock loss, so lock_lost is not set in that
    // case. The counter is zeroed whenever a state is (re-)entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_PLL_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    lost_d  = 1'b1;
                    state_d = ST_PLL_RST;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        if (soft_reset_req) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
            lost_d  = 1'b0;
        end

        if ((state_d != state_q) || soft_reset_req) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself and come straight from flops.
    always_comb begin
        pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    // State and output registers. Reset puts the PLL and the system into
    // reset and starts a fresh pulse from count zero.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign lock_fail   = fail_q;
    assign lock_lost   = lost_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Drives the sequencer with small cycle parameters and compares its outputs
// against edge numbers derived from the lock/reset timing rules. Inputs are
// driven and outputs sampled on the falling edge of refclk.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int P  = 4;
    localparam int L  = 8;
    localparam int T  = 32;
    localparam int R  = 2;
    localparam int RW = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          soft_reset_req = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          lock_fail;
    logic          lock_lost;
    logic [RW-1:0] retry_count;

    int n_cmp = 0;
    int n_bad = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (P),
        .LOCK_STABLE_CYCLES  (L),
        .LOCK_TIMEOUT_CYCLES (T),
        .MAX_RETRIES         (R)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_fail      (lock_fail),
        .lock_lost      (lock_lost),
        .retry_count    (retry_count)
    );

    // 50 MHz reference clock.
    always #10 refclk = ~refclk;

    // Hard stop in case a scenario never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    // Hold rst for two edges and release it on a falling edge; the next
    // rising edge is edge 1 after release.
    task automatic apply_reset();
        rst            = 1'b1;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1;
        tick();
        obs = {pll_rst, sys_rst, ready, lock_fail, lock_lost, retry_count};
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_bad++;
            $display("[TB] FAIL reset_values: got %b, want %b", obs, 7'b1100000);
        end
    endtask

    // Lock rises after edge d (first sampled at edge d+1). Lock is usable by
    // the state logic two edges after it is first sampled, but the state
    // logic only looks at it once the PLL pulse is over.
    task automatic test_bringup(input int d);
        int s, exp_stable, exp_run, fall_e, ready_e;
        logic sys_pre, sys_at;
        apply_reset();
        s          = d + 1;
        exp_stable = (s + 2 > P + 1) ? s + 2 : P + 1;
        exp_run    = exp_stable + L;
        fall_e     = -1;
        ready_e    = -1;
        sys_pre    = 1'b0;
        sys_at     = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (fall_e < 0 && !pll_rst) fall_e = k;
            if (ready_e < 0 && ready) ready_e = k;
            if (k == exp_run - 1) sys_pre = sys_rst;
            if (k == exp_run) sys_at = sys_rst;
            if (k == d) pll_locked = 1'b1;
        end
        n_cmp++;
        if (fall_e != P) begin
            n_bad++;
            $display("[TB] FAIL bringup_pll_rst_fall(d=%0d): got edge %0d, want edge %0d", d, fall_e, P);
        end
        n_cmp++;
        if (ready_e != exp_run) begin
            n_bad++;
            $display("[TB] FAIL bringup_ready_edge(d=%0d): got edge %0d, want edge %0d", d, ready_e, exp_run);
        end
        n_cmp++;
        if (sys_pre !== 1'b1 || sys_at !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bringup_sys_rst_fall(d=%0d): got %b->%b, want 1->0", d, sys_pre, sys_at);
        end
    endtask

    // Lock high 5 cycles, low 2, then high for good. The short high phase is
    // below the stability window, so only the final rise may lead to RUN.
    task automatic test_glitch();
        int d, s2, exp_run, ready_e;
        logic retry_nz;
        apply_reset();
        d        = $urandom_range(4, 10);
        s2       = d + 8;
        exp_run  = ((s2 + 2 > P + 1) ? s2 + 2 : P + 1) + L;
        ready_e  = -1;
        retry_nz = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ready_e < 0 && ready) ready_e = k;
            if (retry_count != '0) retry_nz = 1'b1;
            if (k == d) pll_locked = 1'b1;
            if (k == d + 5) pll_locked = 1'b0;
            if (k == d + 7) pll_locked = 1'b1;
        end
        n_cmp++;
        if (ready_e != exp_run) begin
            n_bad++;
            $display("[TB] FAIL glitch_ready_edge(d=%0d): got edge %0d, want edge %0d", d, ready_e, exp_run);
        end
        n_cmp++;
        if (retry_nz !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL glitch_retry_count: got nonzero=%b, want nonzero=0", retry_nz);
        end
    endtask

    // With no lock at all, every attempt is one pulse plus one full timeout.
    task automatic test_timeout();
        int   fall_edge [0:7];
        int   fall_retry[0:7];
        int   n_fall, fail_e, exp_fail;
        logic prev_rst;
        logic [4:0] obs;
        apply_reset();
        n_fall   = 0;
        fail_e   = -1;
        prev_rst = 1'b1;
        exp_fail = (R + 1) * (P + T);
        for (int k = 1; k <= 140; k++) begin
            tick();
            if (prev_rst && !pll_rst) begin
                if (n_fall < 8) begin
                    fall_edge[n_fall]  = k;
                    fall_retry[n_fall] = int'(retry_count);
                end
                n_fall++;
            end
            prev_rst = pll_rst;
            if (fail_e < 0 && lock_fail) fail_e = k;
        end
        n_cmp++;
        if (n_fall != R + 1) begin
            n_bad++;
            $display("[TB] FAIL timeout_pulse_count: got %0d, want %0d", n_fall, R + 1);
        end
        for (int a = 0; a <= R && a < n_fall; a++) begin
            n_cmp++;
            if (fall_edge[a] != a * (P + T) + P || fall_retry[a] != a) begin
                n_bad++;
                $display("[TB] FAIL timeout_attempt%0d: got edge %0d retry %0d, want edge %0d retry %0d",
                         a, fall_edge[a], fall_retry[a], a * (P + T) + P, a);
            end
        end
        n_cmp++;
        if (fail_e != exp_fail) begin
            n_bad++;
            $display("[TB] FAIL timeout_lock_fail_edge: got edge %0d, want edge %0d", fail_e, exp_fail);
        end
        obs = {pll_rst, sys_rst, ready, lock_fail, lock_lost};
        n_cmp++;
        if (obs !== 5'b11010 || retry_count !== RW'(R)) begin
            n_bad++;
            $display("[TB] FAIL timeout_final_outputs: got %b retry %0d, want %b retry %0d",
                     obs, retry_count, 5'b11010, R);
        end
    endtask

    // From the give-up state, lock alone changes nothing; a soft request
    // starts a fresh pulse, and with lock already present RUN follows.
    task automatic test_recovery();
        int fall_e, ready_e, exp_fall, exp_ready;
        pll_locked = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (lock_fail !== 1'b1 || ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL recovery_stays_failed: got lock_fail=%b ready=%b, want 1 0", lock_fail, ready);
        end
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if ({lock_fail, pll_rst, sys_rst} !== 3'b011 || retry_count !== '0) begin
            n_bad++;
            $display("[TB] FAIL recovery_after_req: got fail/pll/sys=%b retry %0d, want 011 retry 0",
                     {lock_fail, pll_rst, sys_rst}, retry_count);
        end
        exp_fall  = 1 + P;
        exp_ready = exp_fall + 1 + L;
        fall_e    = -1;
        ready_e   = -1;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (fall_e < 0 && !pll_rst) fall_e = k;
            if (ready_e < 0 && ready) ready_e = k;
        end
        n_cmp++;
        if (fall_e != exp_fall || ready_e != exp_ready) begin
            n_bad++;
            $display("[TB] FAIL recovery_timing: got fall %0d ready %0d, want fall %0d ready %0d",
                     fall_e, ready_e, exp_fall, exp_ready);
        end
    endtask

    // Lock dropped in RUN for g sampled cycles, then restored.
    task automatic test_lock_loss();
        int g, s, exp_run, ready_e;
        logic lost_at_run;
        g           = $urandom_range(3, 8);
        s           = g + 1;
        exp_run     = ((s + 2 > 3 + P + 1) ? s + 2 : 3 + P + 1) + L;
        ready_e     = -1;
        lost_at_run = 1'b0;
        pll_locked  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2) begin
                n_cmp++;
                if (ready !== 1'b1 || sys_rst !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL lockloss_edge2_still_run: got ready=%b sys_rst=%b, want 1 0", ready, sys_rst);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if ({sys_rst, lock_lost, pll_rst, ready} !== 4'b1110) begin
                    n_bad++;
                    $display("[TB] FAIL lockloss_edge3: got sys/lost/pll/ready=%b, want 1110",
                             {sys_rst, lock_lost, pll_rst, ready});
                end
            end
            if (k > 3 && ready_e < 0 && ready) begin
                ready_e     = k;
                lost_at_run = lock_lost;
            end
            if (k == g) pll_locked = 1'b1;
        end
        n_cmp++;
        if (ready_e != exp_run || lost_at_run !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL lockloss_relock(g=%0d): got ready edge %0d lost %b, want edge %0d lost 1",
                     g, ready_e, lost_at_run, exp_run);
        end
    endtask

    // From RUN with lock_lost set: lose lock, let one retry happen, relock,
    // then assert rst part-way through STABLE and look before the next edge.
    task automatic test_async_mid_stable();
        int re, s, exp_stable;
        logic [6:0] obs;
        re         = 3 + P + T;
        s          = re + 2;
        exp_stable = (s + 2 > re + P + 1) ? s + 2 : re + P + 1;
        pll_locked = 1'b0;
        for (int k = 1; k <= exp_stable + 3; k++) begin
            tick();
            if (k == re + 1) pll_locked = 1'b1;
        end
        n_cmp++;
        if ({ready, pll_rst, lock_lost} !== 3'b001 || retry_count !== RW'(1)) begin
            n_bad++;
            $display("[TB] FAIL async_pre_stable: got ready/pll/lost=%b retry %0d, want 001 retry 1",
                     {ready, pll_rst, lock_lost}, retry_count);
        end
        #2;
        rst = 1'b1;
        #2;
        obs = {pll_rst, sys_rst, ready, lock_fail, lock_lost, retry_count};
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_bad++;
            $display("[TB] FAIL async_reset_values: got %b, want %b", obs, 7'b1100000);
        end
    endtask

    // Soft request sampled on the same edge that sees the lock loss.
    task automatic test_simultaneous();
        int ready_e;
        apply_reset();
        ready_e = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ready_e < 0 && ready) ready_e = k;
            if (k == 1) pll_locked = 1'b1;
        end
        n_cmp++;
        if (ready_e != P + 1 + L || lock_lost !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL simult_precondition: got ready edge %0d lost %b, want edge %0d lost 0",
                     ready_e, lock_lost, P + 1 + L);
        end
        pll_locked = 1'b0;
        tick();
        tick();
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        n_cmp++;
        if ({lock_lost, pll_rst, sys_rst, ready} !== 4'b0110) begin
            n_bad++;
            $display("[TB] FAIL simult_soft_wins: got lost/pll/sys/ready=%b, want 0110",
                     {lock_lost, pll_rst, sys_rst, ready});
        end
    endtask

    // Scenario sequence; later scenarios start from the state the previous
    // one left behind where noted in each task.
    initial begin
        $display("[TB] start");
        test_reset();
        test_bringup(10);
        test_bringup(int'($urandom_range(1, 20)));
        test_bringup(int'($urandom_range(1, 20)));
        test_glitch();
        test_timeout();
        test_recovery();
        test_lock_loss();
        test_async_mid_stable();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
